// File: rtl/team_00_step_timer.sv
// team_00_step_timer: millisecond/step timing front end for the GPIO sequencer.
// Generates a one-cycle `step` strobe every `prescaler` ms, plus a wrapping
// step index and a `last` flag for the one-hot shifter and done logic.
// Optional feature macro: TEAM_00_LIVE_PRESCALE_EN -- when defined, the step
// period reloads from `prescaler` on every step instead of only at LOAD.
module team_00_step_timer #(
  parameter int CYCLES_PER_MS = 10000,
  parameter int STEPS         = 34
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  input  logic [13:0] prescaler,
  input  logic        start,
  input  logic        stop,
  output logic        running,
  output logic        ms_tick,
  output logic        step,
  output logic [5:0]  step_idx,
  output logic        last
);

  // Guard the degenerate one-cycle-per-ms case so the counter keeps a legal width.
  localparam int             CW       = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [CW-1:0]  CYC_LAST = CW'(CYCLES_PER_MS - 1);
  localparam logic [5:0]     IDX_LAST = 6'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cyc_cnt_reg, cyc_cnt_next;
  logic [13:0]   ms_cnt_reg, ms_cnt_next;
  logic [13:0]   period_reg, period_next;
  logic [5:0]    step_idx_reg, step_idx_next;

  logic [13:0]   prescale_clamped;
  logic          halt;
  logic          in_run;
  logic          cyc_wrap;
  logic          period_wrap;

  // A prescaler of 0 behaves like 1 ms so the block never stalls.
  assign prescale_clamped = (prescaler == 14'd0) ? 14'd1 : prescaler;

  // Disable or stop takes effect in the same cycle: no strobe is issued while halting.
  assign halt        = !en || stop;
  assign in_run      = (state_reg == RUN) && !halt;
  assign cyc_wrap    = (cyc_cnt_reg == CYC_LAST);
  assign period_wrap = (ms_cnt_reg == (period_reg - 14'd1));

  assign running  = (state_reg == LOAD) || (state_reg == RUN);
  assign ms_tick  = in_run && cyc_wrap;
  assign step     = ms_tick && period_wrap;
  assign last     = step && (step_idx_reg == IDX_LAST);
  assign step_idx = step_idx_reg;

  // Next-state and counter update: halt first, then the IDLE -> LOAD -> RUN sequence.
  always_comb begin
    state_next    = state_reg;
    cyc_cnt_next  = cyc_cnt_reg;
    ms_cnt_next   = ms_cnt_reg;
    period_next   = period_reg;
    step_idx_next = step_idx_reg;

    if (halt) begin
      state_next    = IDLE;
      cyc_cnt_next  = '0;
      ms_cnt_next   = '0;
      step_idx_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cyc_cnt_next  = '0;
          ms_cnt_next   = '0;
          step_idx_next = '0;
          if (start) begin
            state_next = LOAD;
          end
        end
        LOAD: begin
          period_next   = prescale_clamped;
          cyc_cnt_next  = '0;
          ms_cnt_next   = '0;
          step_idx_next = '0;
          state_next    = RUN;
        end
        RUN: begin
          if (cyc_wrap) begin
            cyc_cnt_next = '0;
            if (period_wrap) begin
              ms_cnt_next   = '0;
              step_idx_next = (step_idx_reg == IDX_LAST) ? 6'd0 : step_idx_reg + 6'd1;
`ifdef TEAM_00_LIVE_PRESCALE_EN
              // New period applies from the following step onward.
              period_next   = prescale_clamped;
`endif
            end else begin
              ms_cnt_next = ms_cnt_reg + 14'd1;
            end
          end else begin
            cyc_cnt_next = cyc_cnt_reg + CW'(1);
          end
        end
        default: begin
          state_next    = IDLE;
          cyc_cnt_next  = '0;
          ms_cnt_next   = '0;
          step_idx_next = '0;
        end
      endcase
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg    <= IDLE;
      cyc_cnt_reg  <= '0;
      ms_cnt_reg   <= '0;
      period_reg   <= 14'd1;
      step_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cyc_cnt_reg  <= cyc_cnt_next;
      ms_cnt_reg   <= ms_cnt_next;
      period_reg   <= period_next;
      step_idx_reg <= step_idx_next;
    end
  end

endmodule

// File: tb/tb_team_00_step_timer.sv
// Testbench for team_00_step_timer. Uses a short millisecond (CPM cycles) so
// full sequences fit in a short run; expected step events are queued when a
// run is started and popped as the DUT strobes `step`.
module tb_team_00_step_timer;

  localparam int CPM   = 20;
  localparam int STEPS = 34;

  logic        tb_clk = 1'b0;
  logic        nrst;
  logic        en;
  logic [13:0] prescaler;
  logic        start;
  logic        stop;
  logic        running;
  logic        ms_tick;
  logic        step;
  logic [5:0]  step_idx;
  logic        last;

  int cycle   = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int cyc;
    int idx;
    bit lst;
  } exp_t;

  exp_t sb[$];

  team_00_step_timer #(
    .CYCLES_PER_MS(CPM),
    .STEPS(STEPS)
  ) dut (
    .clk(tb_clk),
    .nrst(nrst),
    .en(en),
    .prescaler(prescaler),
    .start(start),
    .stop(stop),
    .running(running),
    .ms_tick(ms_tick),
    .step(step),
    .step_idx(step_idx),
    .last(last)
  );

  always #5 tb_clk = ~tb_clk;

  // Free-running edge counter used as the timebase for expected step times.
  always @(posedge tb_clk) cycle <= cycle + 1;

  // Queue expected steps k = first..first+count-1 of a run started at t0.
  task automatic push_steps(input int t0, input int period, input int first, input int count);
    exp_t e;
    for (int k = first; k < first + count; k++) begin
      e.cyc = t0 + 1 + period * CPM * (k + 1);
      e.idx = k % STEPS;
      e.lst = ((k % STEPS) == STEPS - 1);
      sb.push_back(e);
    end
  endtask

  // Force IDLE for one cycle, then request a run with the given prescaler.
  task automatic restart(input logic [13:0] p, output int t0);
    @(negedge tb_clk);
    stop = 1'b1;
    @(negedge tb_clk);
    stop      = 1'b0;
    start     = 1'b1;
    prescaler = p;
    t0        = cycle;
  endtask

  task automatic test_reset();
    nrst = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0; prescaler = 14'd1;
    repeat (3) @(negedge tb_clk);
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %0b expected 0", running); end
    n_checks++; if (ms_tick !== 1'b0) begin n_fail++; $display("FAIL reset_ms_tick: got %0b expected 0", ms_tick); end
    n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %0b expected 0", step); end
    n_checks++; if (step_idx !== 6'd0) begin n_fail++; $display("FAIL reset_step_idx: got %0d expected 0", step_idx); end
    n_checks++; if (last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b expected 0", last); end
    $display("reset: outputs checked after 3 reset cycles");
    nrst = 1'b1;
  endtask

  task automatic test_idle();
    en = 1'b1; start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge tb_clk);
      n_checks++;
      if ({running, ms_tick, step, last, step_idx} !== 10'd0) begin
        n_fail++;
        $display("FAIL idle_quiet: cycle %0d got run=%0b tick=%0b step=%0b last=%0b idx=%0d expected all 0",
                 cycle, running, ms_tick, step, last, step_idx);
      end
    end
    $display("idle: 500 cycles with start low");
  endtask

  task automatic test_enable_and_wrap();
    int   t0;
    exp_t e;
    bit   exp_tick;
    en = 1'b0; start = 1'b1; prescaler = 14'd1;
    for (int c = 0; c < 350; c++) begin
      @(negedge tb_clk);
      n_checks++;
      if (running !== 1'b0 || step !== 1'b0) begin
        n_fail++;
        $display("FAIL disabled_quiet: cycle %0d got run=%0b step=%0b expected 0 0", cycle, running, step);
      end
    end
    en = 1'b1;
    t0 = cycle;
    push_steps(t0, 1, 0, 2 * STEPS);
    for (int c = 0; c < 2 * STEPS * CPM + 5; c++) begin
      @(negedge tb_clk);
      if (c == 0) begin
        n_checks++;
        if (running !== 1'b1) begin n_fail++; $display("FAIL load_running: got %0b expected 1", running); end
      end
      exp_tick = ((cycle - t0 - 1) > 0) && (((cycle - t0 - 1) % CPM) == 0);
      n_checks++;
      if (ms_tick !== exp_tick) begin
        n_fail++;
        $display("FAIL ms_tick_p1: cycle %0d got %0b expected %0b", cycle, ms_tick, exp_tick);
      end
      if (step === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL extra_step_wrap: cycle %0d got step expected none", cycle);
        end else begin
          e = sb.pop_front();
          $display("step: cycle %0d idx %0d last %0b", cycle, step_idx, last);
          if (cycle !== e.cyc || step_idx !== 6'(e.idx) || last !== e.lst) begin
            n_fail++;
            $display("FAIL step_wrap: got cyc=%0d idx=%0d last=%0b expected cyc=%0d idx=%0d last=%0b",
                     cycle, step_idx, last, e.cyc, e.idx, e.lst);
          end
        end
      end
    end
    n_checks++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL missing_steps_wrap: got %0d left expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_prescale10();
    int   t0;
    exp_t e;
    bit   exp_tick;
    restart(14'd10, t0);
    push_steps(t0, 10, 0, 2);
    for (int c = 0; c < 2 * 10 * CPM + 5; c++) begin
      @(negedge tb_clk);
      exp_tick = ((cycle - t0 - 1) > 0) && (((cycle - t0 - 1) % CPM) == 0);
      n_checks++;
      if (ms_tick !== exp_tick) begin
        n_fail++;
        $display("FAIL ms_tick_p10: cycle %0d got %0b expected %0b", cycle, ms_tick, exp_tick);
      end
      if (step === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL extra_step_p10: cycle %0d got step expected none", cycle);
        end else begin
          e = sb.pop_front();
          $display("step: cycle %0d idx %0d (prescaler 10)", cycle, step_idx);
          if (cycle !== e.cyc || step_idx !== 6'(e.idx)) begin
            n_fail++;
            $display("FAIL step_p10: got cyc=%0d idx=%0d expected cyc=%0d idx=%0d", cycle, step_idx, e.cyc, e.idx);
          end
        end
      end
    end
    n_checks++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL missing_steps_p10: got %0d left expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_prescale0();
    int   t0;
    exp_t e;
    restart(14'd0, t0);
    push_steps(t0, 1, 0, 3);
    for (int c = 0; c < 3 * CPM + 5; c++) begin
      @(negedge tb_clk);
      if (step === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL extra_step_p0: cycle %0d got step expected none", cycle);
        end else begin
          e = sb.pop_front();
          $display("step: cycle %0d idx %0d (prescaler 0)", cycle, step_idx);
          if (cycle !== e.cyc || step_idx !== 6'(e.idx)) begin
            n_fail++;
            $display("FAIL step_p0: got cyc=%0d idx=%0d expected cyc=%0d idx=%0d", cycle, step_idx, e.cyc, e.idx);
          end
        end
      end
    end
    n_checks++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL missing_steps_p0: got %0d left expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_stop();
    int   t0;
    exp_t e;
    restart(14'd10, t0);
    push_steps(t0, 10, 0, 1);
    // Run through one step and into ms_cnt = 5 of the second period.
    for (int c = 0; c < 15 * CPM + 3; c++) begin
      @(negedge tb_clk);
      if (step === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL extra_step_stop: cycle %0d got step expected none", cycle);
        end else begin
          e = sb.pop_front();
          $display("step: cycle %0d idx %0d (before stop)", cycle, step_idx);
          if (cycle !== e.cyc || step_idx !== 6'(e.idx)) begin
            n_fail++;
            $display("FAIL step_stop: got cyc=%0d idx=%0d expected cyc=%0d idx=%0d", cycle, step_idx, e.cyc, e.idx);
          end
        end
      end
    end
    n_checks++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL missing_steps_stop: got %0d left expected 0", sb.size()); sb.delete(); end
    n_checks++;
    if (step_idx !== 6'd1) begin n_fail++; $display("FAIL pre_stop_idx: got %0d expected 1", step_idx); end
    stop = 1'b1;
    @(negedge tb_clk);
    n_checks++;
    if ({running, ms_tick, step, last, step_idx} !== 10'd0) begin
      n_fail++;
      $display("FAIL stop_outputs: got run=%0b tick=%0b step=%0b last=%0b idx=%0d expected all 0",
               running, ms_tick, step, last, step_idx);
    end
    $display("stop: outputs checked one cycle after stop");
    stop = 1'b0;
    t0   = cycle;
    push_steps(t0, 10, 0, 1);
    for (int c = 0; c < 10 * CPM + 5; c++) begin
      @(negedge tb_clk);
      if (c == 0) begin
        n_checks++;
        if (running !== 1'b1 || step_idx !== 6'd0) begin
          n_fail++; $display("FAIL release_load: got run=%0b idx=%0d expected run=1 idx=0", running, step_idx);
        end
      end
      if (step === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL extra_step_release: cycle %0d got step expected none", cycle);
        end else begin
          e = sb.pop_front();
          $display("step: cycle %0d idx %0d (after release)", cycle, step_idx);
          if (cycle !== e.cyc || step_idx !== 6'(e.idx)) begin
            n_fail++;
            $display("FAIL step_release: got cyc=%0d idx=%0d expected cyc=%0d idx=%0d", cycle, step_idx, e.cyc, e.idx);
          end
        end
      end
    end
    n_checks++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL missing_steps_release: got %0d left expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_live_prescale();
    int   t0;
    exp_t e;
    restart(14'd1, t0);
`ifdef TEAM_00_LIVE_PRESCALE_EN
    e.lst = 1'b0;
    e.cyc = t0 + 1 + 1 * CPM; e.idx = 0; sb.push_back(e);
    e.cyc = t0 + 1 + 2 * CPM; e.idx = 1; sb.push_back(e);
    e.cyc = t0 + 1 + 5 * CPM; e.idx = 2; sb.push_back(e);
    e.cyc = t0 + 1 + 8 * CPM; e.idx = 3; sb.push_back(e);
`else
    push_steps(t0, 1, 0, 8);
`endif
    for (int c = 0; c < 8 * CPM + 5; c++) begin
      @(negedge tb_clk);
      if (cycle == t0 + 1 + CPM + 3) prescaler = 14'd3;
      if (step === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL extra_step_live: cycle %0d got step expected none", cycle);
        end else begin
          e = sb.pop_front();
          $display("step: cycle %0d idx %0d (prescaler change)", cycle, step_idx);
          if (cycle !== e.cyc || step_idx !== 6'(e.idx)) begin
            n_fail++;
            $display("FAIL step_live: got cyc=%0d idx=%0d expected cyc=%0d idx=%0d", cycle, step_idx, e.cyc, e.idx);
          end
        end
      end
    end
    n_checks++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL missing_steps_live: got %0d left expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid();
    int   t0;
    exp_t e;
    restart(14'd1, t0);
    push_steps(t0, 1, 0, 2);
    for (int c = 0; c < 2 * CPM + 5; c++) begin
      @(negedge tb_clk);
      if (step === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL extra_step_rst: cycle %0d got step expected none", cycle);
        end else begin
          e = sb.pop_front();
          $display("step: cycle %0d idx %0d (before reset)", cycle, step_idx);
          if (cycle !== e.cyc || step_idx !== 6'(e.idx)) begin
            n_fail++;
            $display("FAIL step_rst: got cyc=%0d idx=%0d expected cyc=%0d idx=%0d", cycle, step_idx, e.cyc, e.idx);
          end
        end
      end
    end
    n_checks++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL missing_steps_rst: got %0d left expected 0", sb.size()); sb.delete(); end
    nrst = 1'b0;
    @(negedge tb_clk);
    n_checks++;
    if ({running, ms_tick, step, last, step_idx} !== 10'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got run=%0b tick=%0b step=%0b last=%0b idx=%0d expected all 0",
               running, ms_tick, step, last, step_idx);
    end
    $display("reset: mid-run reset checked");
    nrst = 1'b1;
    t0   = cycle;
    push_steps(t0, 1, 0, 1);
    for (int c = 0; c < CPM + 5; c++) begin
      @(negedge tb_clk);
      if (step === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL extra_step_post_rst: cycle %0d got step expected none", cycle);
        end else begin
          e = sb.pop_front();
          $display("step: cycle %0d idx %0d (after reset)", cycle, step_idx);
          if (cycle !== e.cyc || step_idx !== 6'(e.idx)) begin
            n_fail++;
            $display("FAIL step_post_rst: got cyc=%0d idx=%0d expected cyc=%0d idx=%0d", cycle, step_idx, e.cyc, e.idx);
          end
        end
      end
    end
    n_checks++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL missing_steps_post_rst: got %0d left expected 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_enable_and_wrap();
    test_prescale10();
    test_prescale0();
    test_stop();
    test_live_prescale();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
